// File: rtl/swi_event_enc_if.sv
// Event handshake between swi_event_enc and its consumer: valid/ready plus
// switch number and on/off direction.
interface swi_event_enc_if;
   logic       ev_valid;
   logic       ev_ready;
   logic [3:0] ev_num;
   logic       ev_on;

   modport master (output ev_valid, output ev_num, output ev_on, input ev_ready);
   modport slave  (input ev_valid, input ev_num, input ev_on, output ev_ready);
endinterface

// File: rtl/swi_event_enc.sv
// Synchronise and debounce 8 slide switches, then emit one valid/ready event per
// debounced transition. Optional macro SWI_ALLON_EV_EN adds a single all-on event.
module swi_event_enc #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned CNT_W           = 18
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      prswi,
   output logic [7:0]      sw_stable,
   output logic            ev_lost,
   swi_event_enc_if.master ev
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, PRESENT} state_t;

   logic [7:0]       sync1, sync2, cand, pending;
   logic [CNT_W-1:0] cnt;
   logic             stable_upd;
   logic [7:0]       diff, diff_eff, keep, clr_mask;
   logic [2:0]       sel_idx;
   state_t           state, state_nxt;
   logic             load_ev, load_on;
   logic [3:0]       load_num;
`ifdef SWI_ALLON_EV_EN
   logic             allon_flag, allon_hit, clr_flag;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= '0;
         sync2     <= '0;
         cand      <= '0;
         sw_stable <= '0;
         cnt       <= '0;
      end else begin
         sync1 <= prswi;
         sync2 <= sync1;
         if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
         end else if (cnt == CNT_MAX) begin
            sw_stable <= cand;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Counter saturates at CNT_MAX, so the update strobe repeats; diff is zero then.
   assign stable_upd = (sync2 == cand) && (cnt == CNT_MAX);
   assign diff       = stable_upd ? (cand ^ sw_stable) : '0;

`ifdef SWI_ALLON_EV_EN
   assign allon_hit = stable_upd && (cand == 8'hFF) && (sw_stable != 8'hFF);
   assign diff_eff  = allon_hit ? '0 : diff;
`else
   assign diff_eff  = diff;
`endif

   always_comb begin
      sel_idx = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (pending[7-i]) sel_idx = 3'(7 - i);
      end
   end

   always_comb begin
      state_nxt = state;
      load_ev   = 1'b0;
      load_num  = '0;
      load_on   = 1'b0;
      clr_mask  = '0;
`ifdef SWI_ALLON_EV_EN
      clr_flag  = 1'b0;
`endif
      unique case (state)
         IDLE: begin
`ifdef SWI_ALLON_EV_EN
            if (allon_flag) begin
               load_ev   = 1'b1;
               load_num  = 4'hA;
               load_on   = 1'b1;
               clr_flag  = 1'b1;
               state_nxt = PRESENT;
            end else
`endif
            if (pending != '0) begin
               load_ev           = 1'b1;
               load_num          = {1'b0, sel_idx};
               load_on           = sw_stable[sel_idx];
               clr_mask[sel_idx] = 1'b1;
               state_nxt         = PRESENT;
            end
         end
         PRESENT: if (ev.ev_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Clear the selected bit before merging new diffs so a fresh toggle re-arms it.
   assign keep = pending & ~clr_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pending     <= '0;
         ev_lost     <= 1'b0;
         ev.ev_valid <= 1'b0;
         ev.ev_num   <= '0;
         ev.ev_on    <= 1'b0;
      end else begin
         state       <= state_nxt;
         pending     <= keep ^ diff_eff;
         ev.ev_valid <= (state_nxt == PRESENT);
         if (|(keep & diff_eff)) ev_lost <= 1'b1;
         if (load_ev) begin
            ev.ev_num <= load_num;
            ev.ev_on  <= load_on;
         end
      end
   end

`ifdef SWI_ALLON_EV_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         allon_flag <= 1'b0;
      else if (allon_hit) allon_flag <= 1'b1;
      else if (clr_flag)  allon_flag <= 1'b0;
   end
`endif
endmodule

// File: tb/tb_swi_event_enc.sv
// Self-checking bench for swi_event_enc: directed scenarios plus random switch
// activity, checked every cycle against a behavioural model.
module tb_swi_event_enc;
   localparam int unsigned DB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] prswi;
   logic [7:0] sw_stable;
   logic       ev_lost;

   swi_event_enc_if evif ();

   swi_event_enc #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .prswi     (prswi),
      .sw_stable (sw_stable),
      .ev_lost   (ev_lost),
      .ev        (evif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: raw sample history, stable vector, pending set, presented event.
   logic [7:0] hist[$];
   logic [7:0] m_stable, m_pend;
   logic       m_lost, m_busy, m_on, m_flag;
   logic [3:0] m_num;

   int         first_k, vcount, seen;
   logic [7:0] orv;
   logic [3:0] nums[$];
   logic       ons[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < int'(DB) + 3; i++) hist.push_back(8'h00);
      m_stable = '0; m_pend = '0; m_lost = 0; m_busy = 0;
      m_on = 0; m_num = '0; m_flag = 0;
   endtask

   // Stable takes the raw value seen two edges earlier once DB+1 consecutive samples agree.
   task automatic model_edge(input logic [7:0] smp, input logic rdy);
      logic [7:0] ns, d, refv;
      bit same;
      int n, lo;
      hist.push_back(smp);
      while (hist.size() > int'(DB) + 3) void'(hist.pop_front());
      n = hist.size();
      refv = hist[n-3];
      same = 1;
      for (int k = n - 3 - int'(DB); k <= n - 3; k++) if (hist[k] !== refv) same = 0;
      ns = same ? refv : m_stable;
      if (m_busy) begin
         if (rdy) m_busy = 0;
      end else begin
`ifdef SWI_ALLON_EV_EN
         if (m_flag) begin
            m_num = 4'hA; m_on = 1; m_flag = 0; m_busy = 1;
         end else
`endif
         if (m_pend != 0) begin
            lo = 0;
            for (int i = 7; i >= 0; i--) if (m_pend[i]) lo = i;
            m_num = 4'(lo); m_on = m_stable[lo]; m_pend[lo] = 1'b0; m_busy = 1;
         end
      end
      d = ns ^ m_stable;
`ifdef SWI_ALLON_EV_EN
      if (ns == 8'hFF && m_stable != 8'hFF) begin m_flag = 1; d = '0; end
`endif
      if ((m_pend & d) != 0) m_lost = 1;
      m_pend = m_pend ^ d;
      m_stable = ns;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge(prswi, evif.ev_ready);
      #1;
      chk("sw_stable", 32'(sw_stable), 32'(m_stable));
      chk("ev_valid", 32'(evif.ev_valid), 32'(m_busy));
      chk("ev_num", 32'(evif.ev_num), 32'(m_num));
      chk("ev_on", 32'(evif.ev_on), 32'(m_on));
      chk("ev_lost", 32'(ev_lost), 32'(m_lost));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      chk("rst_stable", 32'(sw_stable), 0);
      chk("rst_valid", 32'(evif.ev_valid), 0);
      chk("rst_num", 32'(evif.ev_num), 0);
      chk("rst_on", 32'(evif.ev_on), 0);
      chk("rst_lost", 32'(ev_lost), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      prswi = 8'h00;
      evif.ev_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      do_reset();

      // Idle after reset: no events for 50 cycles
      run(50);

      // Single switch on: latency and one-cycle event
      prswi = 8'h04;
      first_k = -1; vcount = 0;
      for (int k = 1; k <= 20; k++) begin
         cycle();
         if (first_k < 0 && sw_stable == 8'h04) first_k = k;
         if (evif.ev_valid) begin
            vcount++;
            chk("sw2_num", 32'(evif.ev_num), 2);
            chk("sw2_on", 32'(evif.ev_on), 1);
         end
      end
      chk("lat04", 32'(first_k), 7);
      chk("sw2_evcount", 32'(vcount), 1);
      prswi = 8'h00;
      run(20);

      // Short glitch never reaches the stable vector
      prswi = 8'h01;
      run(3);
      prswi = 8'h00;
      orv = '0; vcount = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         orv |= sw_stable;
         if (evif.ev_valid) vcount++;
      end
      chk("glitch_stable", 32'(orv), 0);
      chk("glitch_ev", 32'(vcount), 0);

      // Two switches with consumer stalled: held event, then next one
      evif.ev_ready = 1'b0;
      prswi = 8'h81;
      seen = 0;
      for (int k = 0; k < 30 && !seen; k++) begin
         cycle();
         if (evif.ev_valid) seen = 1;
      end
      chk("stall_seen", 32'(seen), 1);
      for (int k = 0; k < 20; k++) begin
         cycle();
         chk("stall_valid", 32'(evif.ev_valid), 1);
         chk("stall_num", 32'(evif.ev_num), 0);
         chk("stall_on", 32'(evif.ev_on), 1);
      end
      evif.ev_ready = 1'b1;
      cycle();
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         cycle();
         if (evif.ev_valid) seen = 1;
      end
      chk("second_seen", 32'(seen), 1);
      chk("second_num", 32'(evif.ev_num), 7);
      chk("second_on", 32'(evif.ev_on), 1);
      run(10);
      chk("after81_valid", 32'(evif.ev_valid), 0);
      prswi = 8'h00;
      run(20);

      // Switch 3 toggles twice while its event waits behind switch 0
      evif.ev_ready = 1'b0;
      prswi = 8'h01;
      run(12);
      prswi = 8'h09;
      run(12);
      prswi = 8'h01;
      run(12);
      chk("lost_flag", 32'(ev_lost), 1);
      evif.ev_ready = 1'b1;
      run(10);
      prswi = 8'h00;
      run(20);

      // All switches on together
      do_reset();
      run(10);
      prswi = 8'hFF;
      nums.delete(); ons.delete();
      for (int k = 0; k < 40; k++) begin
         cycle();
         if (evif.ev_valid) begin nums.push_back(evif.ev_num); ons.push_back(evif.ev_on); end
      end
`ifdef SWI_ALLON_EV_EN
      chk("allon_count", 32'(nums.size()), 1);
      if (nums.size() == 1) begin
         chk("allon_num", 32'(nums[0]), 32'hA);
         chk("allon_on", 32'(ons[0]), 1);
      end
`else
      chk("ff_count", 32'(nums.size()), 8);
      for (int i = 0; i < nums.size() && i < 8; i++) begin
         chk("ff_num", 32'(nums[i]), 32'(i));
         chk("ff_on", 32'(ons[i]), 1);
      end
`endif
      prswi = 8'h00;
      run(40);

      // Random switch activity and consumer back-pressure
      for (int s = 0; s < 250; s++) begin
         if ($urandom_range(0, 3) == 0) prswi = prswi ^ (8'h01 << $urandom_range(0, 7));
         else if ($urandom_range(0, 7) == 0) prswi = 8'($urandom);
         for (int k = 0, n = $urandom_range(1, 12); k < n; k++) begin
            evif.ev_ready = ($urandom_range(0, 2) != 0);
            cycle();
         end
         if (s == 120) do_reset();
      end
      evif.ev_ready = 1'b1;
      run(60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/swi_event_enc.md
Name: swi_event_enc

Overview:
- Input-side counterpart to the switch/LED/7-seg display path.
- Synchronises and debounces the 8 DIP slide switches and holds a clean switch vector.
- Encodes each debounced switch transition as a numbered event (switch number plus on/off) on a valid/ready interface.
- A downstream consumer (display sequencer, UART logger) takes events one at a time, without polling raw switches.

Parameters:
- DEBOUNCE_CYCLES, 250000, clock cycles the synchronised vector must stay unchanged before it is accepted (min 2).
- CNT_W, 18, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- prswi  input  8  raw slide switch levels, asynchronous, 1 = on.
- sw_stable  output  8  debounced switch vector.
- ev_valid  output  1  event available.
- ev_ready  input  1  consumer accepts event when high with ev_valid.
- ev_num  output  4  switch number 0..7; 4'hA = all-on event (optional feature only).
- ev_on  output  1  1 = switch turned on, 0 = turned off.
- ev_lost  output  1  sticky; a pending bit toggled twice before emission.

Behaviour:
- Reset (async assert, sync release):
  - sync1, sync2, cand, sw_stable = 8'h00; cnt = 0; pending = 8'h00.
  - ev_valid = 0; ev_num = 0; ev_on = 0; ev_lost = 0; state = IDLE.
  - Reset mid-event drops the event and all pending bits.
- Synchroniser: 2-flop chain per bit, prswi -> sync1 -> sync2.
- Debounce uses one shared counter for the whole vector:
  - sync2 != cand: cand <= sync2, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: sw_stable <= cand, cnt holds.
  - Else: cnt <= cnt+1.
  - Latency: sw_stable takes the new value on edge DEBOUNCE_CYCLES+2 after the edge that first samples the raw change into sync1.
  - A raw glitch shorter than DEBOUNCE_CYCLES cycles never reaches sw_stable.
- Change detection: on the edge sw_stable updates, diff = new ^ old.
  - pending <= pending ^ diff.
  - A bit that was already pending and toggles again clears its pending bit (net no change) and sets ev_lost.
  - ev_lost clears only on reset.
- Event FSM:
  - IDLE:
    - pending != 0 -> PRESENT.
    - Select the lowest set pending index i.
    - ev_num <= i; ev_on <= sw_stable[i].
    - Clear pending[i] on the same edge.
    - ev_valid <= 1, one cycle after the sw_stable update at the earliest.
  - PRESENT:
    - ev_valid, ev_num and ev_on are held stable while ev_ready = 0.
    - ev_valid && ev_ready -> IDLE, ev_valid <= 0.
    - Minimum 2 cycles per event; no back-to-back valid.
- Simultaneous events: a stable update in the same cycle as selection/clear merges correctly. A new diff on bit i in the clearing cycle sets pending[i] again.
- Multiple switches changing inside one debounce window produce one event per changed bit, lowest index first.

Optional Feature:
- Macro: SWI_ALLON_EV_EN.
- Defined:
  - When sw_stable transitions to 8'hFF from any other value, per-bit diffs of that update are discarded.
  - A single all-on flag is set instead.
  - In IDLE the flag has priority over pending bits; it emits ev_num = 4'hA, ev_on = 1, and clears the flag.
  - Leaving 8'hFF generates normal per-bit off events.
- Undefined: no flag logic; 8'hFF transitions produce per-bit events only; ev_num never exceeds 7.

Test Plan:
- Reset with prswi = 8'h00, DEBOUNCE_CYCLES = 4 -> all outputs 0; no ev_valid for 50 cycles.
- prswi 8'h00 -> 8'h04, ev_ready = 1 -> sw_stable = 8'h04 exactly 6 edges after sampling; one event ev_num = 2, ev_on = 1, valid for 1 cycle.
- prswi pulses 8'h01 for 3 cycles (DEBOUNCE_CYCLES = 4) -> sw_stable stays 8'h00; no event.
- prswi 8'h00 -> 8'h81 with ev_ready = 0 for 20 cycles -> ev_num = 0, ev_on = 1 held 20 cycles; after ready, ev_num = 7, ev_on = 1; then idle.
- Switch 3 on, then off again while its event is still pending (ev_ready low) -> pending[3] nets to 0, ev_lost = 1.
- With SWI_ALLON_EV_EN, prswi 8'h00 -> 8'hFF -> single event ev_num = 4'hA, ev_on = 1. Without it -> 8 events, ev_num 0..7 in order.
